// File: rtl/tabellone_pkg.sv
// Shared types and default widths for the tabellone scoreboard and the game block.
// Optional feature macro used by the top: TABELLONE_SERIE_EN.
package tabellone_pkg;

    typedef enum logic [1:0] {
        NULLA   = 2'b00,
        PRIMO   = 2'b01,
        SECONDO = 2'b10,
        PARI    = 2'b11
    } esito_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        GIOCO = 2'b10,
        FINE  = 2'b11
    } stato_t;

    localparam int CNT_W_DEF  = 8;
    localparam int TURN_W_DEF = 5;

endpackage

// File: rtl/tabellone_contatore_sat.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module contatore_sat #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] satInc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= satInc(cnt);
        end
    end

endmodule

// File: rtl/tabellone.sv
// Scoreboard: per-game turn counts, saturating cross-game totals, end-of-game strobe.
// Define TABELLONE_SERIE_EN to add longest-winning-streak outputs per player.
module tabellone
    import tabellone_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TURN_W = TURN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INIZIA,
    input  logic [1:0]        MANCHE,
    input  logic [1:0]        PARTITA,
    output logic [TURN_W-1:0] MANCHE_PRIMO,
    output logic [TURN_W-1:0] MANCHE_SECONDO,
    output logic [TURN_W-1:0] MANCHE_PARI,
    output logic [TURN_W-1:0] MANCHE_NULLE,
    output logic [CNT_W-1:0]  VITTORIE_PRIMO,
    output logic [CNT_W-1:0]  VITTORIE_SECONDO,
    output logic [CNT_W-1:0]  PAREGGI,
`ifdef TABELLONE_SERIE_EN
    output logic [TURN_W-1:0] SERIE_PRIMO,
    output logic [TURN_W-1:0] SERIE_SECONDO,
`endif
    output logic [1:0]        ULTIMO_ESITO,
    output logic              RISULTATO_VALIDO,
    output logic [1:0]        STATO
);

    stato_t stato, statoNext;
    esito_t manche, partita;
    logic   inSetup, inGioco, fineGioco;

    assign manche    = esito_t'(MANCHE);
    assign partita   = esito_t'(PARTITA);
    assign inSetup   = (stato == SETUP);
    // A restart in GIOCO abandons the game, so nothing is counted on that edge.
    assign inGioco   = (stato == GIOCO) && !INIZIA;
    assign fineGioco = inGioco && (partita != NULLA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stato <= IDLE;
        end else begin
            stato <= statoNext;
        end
    end

    always_comb begin
        statoNext        = stato;
        RISULTATO_VALIDO = 1'b0;
        STATO            = stato;
        if (INIZIA) begin
            statoNext = SETUP;
        end else begin
            case (stato)
                IDLE:  statoNext = IDLE;
                SETUP: statoNext = GIOCO;
                GIOCO: if (partita != NULLA) statoNext = FINE;
                FINE:  statoNext = IDLE;
            endcase
        end
        if (stato == FINE) RISULTATO_VALIDO = 1'b1;
    end

    contatore_sat #(.W(TURN_W)) uMancheNulle (
        .clk(clk), .rst_n(rst_n), .clr(inSetup),
        .en(inGioco && manche == NULLA), .cnt(MANCHE_NULLE));
    contatore_sat #(.W(TURN_W)) uManchePrimo (
        .clk(clk), .rst_n(rst_n), .clr(inSetup),
        .en(inGioco && manche == PRIMO), .cnt(MANCHE_PRIMO));
    contatore_sat #(.W(TURN_W)) uMancheSecondo (
        .clk(clk), .rst_n(rst_n), .clr(inSetup),
        .en(inGioco && manche == SECONDO), .cnt(MANCHE_SECONDO));
    contatore_sat #(.W(TURN_W)) uManchePari (
        .clk(clk), .rst_n(rst_n), .clr(inSetup),
        .en(inGioco && manche == PARI), .cnt(MANCHE_PARI));

    // Match totals survive SETUP; only rst_n clears them.
    contatore_sat #(.W(CNT_W)) uVittoriePrimo (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .en(fineGioco && partita == PRIMO), .cnt(VITTORIE_PRIMO));
    contatore_sat #(.W(CNT_W)) uVittorieSecondo (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .en(fineGioco && partita == SECONDO), .cnt(VITTORIE_SECONDO));
    contatore_sat #(.W(CNT_W)) uPareggi (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .en(fineGioco && partita == PARI), .cnt(PAREGGI));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ULTIMO_ESITO <= 2'b00;
        end else if (fineGioco) begin
            ULTIMO_ESITO <= PARTITA;
        end
    end

`ifdef TABELLONE_SERIE_EN
    logic [TURN_W-1:0] runPrimo, runSecondo, runPrimoNext, runSecondoNext;

    function automatic logic [TURN_W-1:0] satInc(input logic [TURN_W-1:0] v);
        return (&v) ? v : v + TURN_W'(1);
    endfunction

    assign runPrimoNext   = satInc(runPrimo);
    assign runSecondoNext = satInc(runSecondo);

    // Invalid turns leave both runs untouched; draws break both.
    contatore_sat #(.W(TURN_W)) uRunPrimo (
        .clk(clk), .rst_n(rst_n),
        .clr(inSetup || (inGioco && (manche == SECONDO || manche == PARI))),
        .en(inGioco && manche == PRIMO), .cnt(runPrimo));
    contatore_sat #(.W(TURN_W)) uRunSecondo (
        .clk(clk), .rst_n(rst_n),
        .clr(inSetup || (inGioco && (manche == PRIMO || manche == PARI))),
        .en(inGioco && manche == SECONDO), .cnt(runSecondo));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SERIE_PRIMO   <= '0;
            SERIE_SECONDO <= '0;
        end else if (inSetup) begin
            SERIE_PRIMO   <= '0;
            SERIE_SECONDO <= '0;
        end else if (inGioco) begin
            if (manche == PRIMO && runPrimoNext > SERIE_PRIMO)
                SERIE_PRIMO <= runPrimoNext;
            if (manche == SECONDO && runSecondoNext > SERIE_SECONDO)
                SERIE_SECONDO <= runSecondoNext;
        end
    end
`endif

endmodule

// File: tb/tb_tabellone.sv
// Randomised and directed bench for tabellone against a behavioural scoreboard model.
module tb_tabellone;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       INIZIA = 1'b0;
    logic [1:0] MANCHE = 2'b00;
    logic [1:0] PARTITA = 2'b00;
    logic [4:0] MANCHE_PRIMO, MANCHE_SECONDO, MANCHE_PARI, MANCHE_NULLE;
    logic [7:0] VITTORIE_PRIMO, VITTORIE_SECONDO, PAREGGI;
    logic [1:0] ULTIMO_ESITO, STATO;
    logic       RISULTATO_VALIDO;
`ifdef TABELLONE_SERIE_EN
    logic [4:0] SERIE_PRIMO, SERIE_SECONDO;
`endif

    int nChecks = 0;
    int nFails  = 0;

    tabellone dut (
        .clk(clk), .rst_n(rst_n), .INIZIA(INIZIA), .MANCHE(MANCHE), .PARTITA(PARTITA),
        .MANCHE_PRIMO(MANCHE_PRIMO), .MANCHE_SECONDO(MANCHE_SECONDO),
        .MANCHE_PARI(MANCHE_PARI), .MANCHE_NULLE(MANCHE_NULLE),
        .VITTORIE_PRIMO(VITTORIE_PRIMO), .VITTORIE_SECONDO(VITTORIE_SECONDO),
        .PAREGGI(PAREGGI),
`ifdef TABELLONE_SERIE_EN
        .SERIE_PRIMO(SERIE_PRIMO), .SERIE_SECONDO(SERIE_SECONDO),
`endif
        .ULTIMO_ESITO(ULTIMO_ESITO), .RISULTATO_VALIDO(RISULTATO_VALIDO), .STATO(STATO)
    );

    always #5 clk = ~clk;

    // Model: phase uses the documented STATO codes (0 idle, 1 setup, 2 game, 3 end).
    int phase;
    int turn[4];   // indexed by MANCHE code
    int tot[4];    // indexed by PARTITA code, entry 0 unused
    int last;
    int run[4];
    int best[4];

    function automatic int sat(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; last = 0;
            for (int k = 0; k < 4; k++) begin
                turn[k] = 0; tot[k] = 0; run[k] = 0; best[k] = 0;
            end
        end else begin
            int nextPhase;
            case (phase)
                1: nextPhase = 2;
                2: nextPhase = (PARTITA != 0) ? 3 : 2;
                default: nextPhase = 0;
            endcase
            if (phase == 1) begin
                for (int k = 0; k < 4; k++) begin
                    turn[k] = 0; run[k] = 0; best[k] = 0;
                end
            end else if (phase == 2 && !INIZIA) begin
                turn[MANCHE] = sat(turn[MANCHE] + 1, 31);
                if (MANCHE == 1 || MANCHE == 2) begin
                    run[MANCHE] = sat(run[MANCHE] + 1, 31);
                    run[3 - MANCHE] = 0;
                    if (run[MANCHE] > best[MANCHE]) best[MANCHE] = run[MANCHE];
                end else if (MANCHE == 3) begin
                    run[1] = 0; run[2] = 0;
                end
                if (PARTITA != 0) begin
                    tot[PARTITA] = sat(tot[PARTITA] + 1, 255);
                    last = PARTITA;
                end
            end
            phase = INIZIA ? 1 : nextPhase;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stato", STATO, phase);
        chk("valido", RISULTATO_VALIDO, (phase == 3) ? 1 : 0);
        chk("nulle", MANCHE_NULLE, turn[0]);
        chk("m_primo", MANCHE_PRIMO, turn[1]);
        chk("m_secondo", MANCHE_SECONDO, turn[2]);
        chk("pari", MANCHE_PARI, turn[3]);
        chk("v_primo", VITTORIE_PRIMO, tot[1]);
        chk("v_secondo", VITTORIE_SECONDO, tot[2]);
        chk("pareggi", PAREGGI, tot[3]);
        chk("ultimo", ULTIMO_ESITO, last);
`ifdef TABELLONE_SERIE_EN
        chk("serie_primo", SERIE_PRIMO, best[1]);
        chk("serie_secondo", SERIE_SECONDO, best[2]);
`endif
    end

    task automatic step(input logic i, input logic [1:0] m, input logic [1:0] p);
        INIZIA = i; MANCHE = m; PARTITA = p;
        @(posedge clk);
        #1;
    endtask

    task automatic newGame();
        step(1'b1, 2'd0, 2'd0);
        step(1'b0, 2'd0, 2'd0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stato", STATO, 0);
        chk("rst_vprimo", VITTORIE_PRIMO, 0);
        chk("rst_valido", RISULTATO_VALIDO, 0);
        releaseReset();

        // Game 1: PRIMO wins on the fifth turn.
        step(1'b1, 2'd0, 2'd0);
        step(1'b1, 2'd0, 2'd0);
        step(1'b0, 2'd0, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd1, 2'd1);
        chk("g1_mprimo", MANCHE_PRIMO, 4);
        chk("g1_msecondo", MANCHE_SECONDO, 1);
        chk("g1_vprimo", VITTORIE_PRIMO, 1);
        chk("g1_ultimo", ULTIMO_ESITO, 1);
        chk("g1_valido", RISULTATO_VALIDO, 1);
        step(1'b0, 2'd0, 2'd0);
        chk("g1_valido_off", RISULTATO_VALIDO, 0);
        chk("g1_idle", STATO, 0);
        chk("g1_hold", MANCHE_PRIMO, 4);

        // Game 2: invalid turns and a draw, SECONDO wins.
        newGame();
        step(1'b0, 2'd0, 2'd0);
        step(1'b0, 2'd3, 2'd0);
        step(1'b0, 2'd0, 2'd0);
        step(1'b0, 2'd2, 2'd2);
        chk("g2_nulle", MANCHE_NULLE, 2);
        chk("g2_pari", MANCHE_PARI, 1);
        chk("g2_msecondo", MANCHE_SECONDO, 1);
        chk("g2_vsecondo", VITTORIE_SECONDO, 1);
        step(1'b0, 2'd0, 2'd0);

        // Restart on the same edge as a drawn result: game abandoned.
        newGame();
        step(1'b0, 2'd1, 2'd0);
        step(1'b1, 2'd1, 2'd3);
        chk("ab_setup", STATO, 1);
        chk("ab_pareggi", PAREGGI, 0);
        chk("ab_valido", RISULTATO_VALIDO, 0);
        step(1'b1, 2'd0, 2'd0);
        chk("ab_clear", MANCHE_PRIMO, 0);
        chk("ab_vprimo", VITTORIE_PRIMO, 1);

`ifdef TABELLONE_SERIE_EN
        newGame();
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd0, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        chk("serie_p_lit", SERIE_PRIMO, 3);
        chk("serie_s_lit", SERIE_SECONDO, 1);
`endif

        // Invalid turns saturate the per-game counter.
        newGame();
        for (int k = 0; k < 40; k++) step(1'b0, 2'd0, 2'd0);
        chk("sat_nulle", MANCHE_NULLE, 31);
        step(1'b0, 2'd0, 2'd1);
        step(1'b0, 2'd0, 2'd0);

        // Enough PRIMO games to saturate the match total.
        for (int g = 0; g < 256; g++) begin
            newGame();
            step(1'b0, 2'd1, 2'd1);
            step(1'b0, 2'd0, 2'd0);
        end
        chk("sat_vprimo", VITTORIE_PRIMO, 255);

        // Asynchronous reset in the middle of a game.
        newGame();
        step(1'b0, 2'd1, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_g_stato", STATO, 0);
        chk("arst_g_mprimo", MANCHE_PRIMO, 0);
        chk("arst_g_vprimo", VITTORIE_PRIMO, 0);
        chk("arst_g_vsecondo", VITTORIE_SECONDO, 0);
        releaseReset();

        // Asynchronous reset during the end-of-game strobe.
        newGame();
        step(1'b0, 2'd2, 2'd2);
        chk("fine_valido", RISULTATO_VALIDO, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_f_valido", RISULTATO_VALIDO, 0);
        chk("arst_f_stato", STATO, 0);
        chk("arst_f_vsecondo", VITTORIE_SECONDO, 0);
        chk("arst_f_ultimo", ULTIMO_ESITO, 0);
        releaseReset();

        // Random traffic, checked every cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            logic       ri;
            logic [1:0] rm, rp;
            ri = ($urandom_range(0, 15) == 0);
            rm = 2'($urandom_range(0, 3));
            rp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            step(ri, rm, rp);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_arst_stato", STATO, 0);
                releaseReset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
